// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Boot-time program loader. Takes a byte stream (typically from a UART
//   receiver), assembles little-endian 32-bit words and writes them into core
//   memory from BASE_ADDR upward. The core is held in reset until the whole
//   image has been written.
//
//   Stream format: 4-byte little-endian length N (in bytes), then N payload
//   bytes. A final partial word is written with its unfilled upper bytes zero.
//   An image longer than the memory space above BASE_ADDR is refused: no
//   writes happen, error is raised and the core stays in reset.
//
// Parameters
//   ADDR_WIDTH  byte-address width of core memory (capacity 2**ADDR_WIDTH bytes)
//   BASE_ADDR   byte address of the first word written (4-byte aligned)
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   in_valid   in   input byte valid
//   in_data    in   input byte
//   in_ready   out  byte accepted this cycle when in_valid is also high
//   mem_we     out  one-cycle word write strobe
//   mem_addr   out  word-aligned byte address of the write
//   mem_wdata  out  write data, first stream byte of the group in [7:0]
//   core_rst   out  reset to the core, high until the load completes
//   done       out  image fully written, core released
//   error      out  image length exceeds capacity, sticky until rst
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int ADDR_WIDTH = 16,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [7:0]            in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  core_rst,
   output logic                  done,
   output logic                  error
);

   typedef enum logic [2:0] {
      S_LEN,
      S_DATA,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_t;

   // Bytes available from BASE_ADDR to the top of memory; 33 bits so that a
   // 32-bit length can be compared without overflow.
   localparam logic [32:0]           CAPACITY = (33'd1 << ADDR_WIDTH) - 33'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-1:0] BASE_A   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH-3:0] WIDX_ONE = 1;

   state_t                r_state;
   logic [31:0]           r_len;
   logic [31:0]           r_cnt;
   logic [31:0]           r_buf;
   logic [31:0]           r_wdata;
   logic [ADDR_WIDTH-3:0] r_widx;
   logic                  r_in_ready;
   logic                  r_mem_we;
   logic                  r_core_rst;
   logic                  r_done;
   logic                  r_error;

   logic                  w_xfer;
   logic [1:0]            w_k;
   logic [31:0]           w_len_full;
   logic [31:0]           w_cnt_nxt;
   logic                  w_last;
   logic [31:0]           w_word;

   assign w_xfer     = in_valid & r_in_ready;
   assign w_k        = r_cnt[1:0];
   assign w_len_full = {in_data, r_len[23:0]};
   assign w_cnt_nxt  = r_cnt + 32'd1;
   assign w_last     = (w_cnt_nxt == r_len);

   // Current group with the incoming byte merged at its lane. The buffer is
   // cleared after every write, so lanes above w_k are always zero here.
   always_comb begin
      w_word                      = r_buf;
      w_word[{w_k, 3'b000} +: 8] = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_LEN;
         r_len      <= '0;
         r_cnt      <= '0;
         r_buf      <= '0;
         r_wdata    <= '0;
         r_widx     <= '0;
         r_in_ready <= 1'b0;
         r_mem_we   <= 1'b0;
         r_core_rst <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_mem_we <= 1'b0;
         // The address moves on only after the write cycle has completed.
         if (r_mem_we) r_widx <= r_widx + WIDX_ONE;

         case (r_state)
            S_LEN: begin
               r_in_ready <= 1'b1;
               if (w_xfer) begin
                  r_len[{w_k, 3'b000} +: 8] <= in_data;
                  r_cnt                     <= w_cnt_nxt;
                  if (w_k == 2'd3) begin
                     r_cnt <= '0;
                     r_len <= w_len_full;
                     if (w_len_full == 32'd0) begin
                        r_state    <= S_DONE;
                        r_in_ready <= 1'b0;
                        r_core_rst <= 1'b0;
                        r_done     <= 1'b1;
                     end else if ({1'b0, w_len_full} > CAPACITY) begin
                        r_state    <= S_ERR;
                        r_in_ready <= 1'b0;
                        r_error    <= 1'b1;
                     end else begin
                        r_state <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (w_xfer) begin
                  r_cnt <= w_cnt_nxt;
                  if ((w_k == 2'd3) || w_last) begin
                     r_mem_we <= 1'b1;
                     r_wdata  <= w_word;
                     r_buf    <= '0;
                  end else begin
                     r_buf <= w_word;
                  end
                  if (w_last) begin
                     r_state    <= S_FLUSH;
                     r_in_ready <= 1'b0;
                  end
               end
            end

            // The final write pulse is on the outputs during this cycle.
            S_FLUSH: begin
               r_state    <= S_DONE;
               r_done     <= 1'b1;
               r_core_rst <= 1'b0;
            end

            default: begin
               // S_DONE / S_ERR hold until rst.
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign mem_we    = r_mem_we;
   assign mem_addr  = BASE_A + {r_widx, 2'b00};
   assign mem_wdata = r_wdata;
   assign core_rst  = r_core_rst;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Two loader instances share one input stream: one at BASE_ADDR 0 and one at
//   BASE_ADDR 0x100. Expected writes are queued per instance as the completing
//   byte is driven and popped by a monitor whenever mem_we is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int AW = 16;
   localparam int B1 = 32'h100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;

   logic          rdy0, we0, crst0, done0, err0;
   logic [AW-1:0] addr0;
   logic [31:0]   wd0;
   logic          rdy1, we1, crst1, done1, err1;
   logic [AW-1:0] addr1;
   logic [31:0]   wd1;

   always #5 clk = ~clk;

   imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
      .core_rst(crst0), .done(done0), .error(err0)
   );

   imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(B1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
      .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
      .core_rst(crst1), .done(done1), .error(err1)
   );

   int total = 0;
   int bad   = 0;
   int nw0   = 0;
   int nw1   = 0;

   logic [47:0] q0[$];
   logic [47:0] q1[$];

   typedef struct {
      int          nb;     // total stream bytes including header
      logic [7:0]  b[12];
      bit          gaps;
      int          nw;     // expected number of write pulses
      logic [31:0] w[2];   // expected words in write order
      bit          err;
   } vec_t;

   vec_t tv[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Write monitor / scoreboard.
   always @(negedge clk) begin
      logic [47:0] e;
      if (we0 === 1'b1) begin
         nw0++;
         if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_we0: got write @%h data %h want none", addr0, wd0);
         end else begin
            e = q0.pop_front();
            chk("wr_addr0", 32'(addr0), 32'(e[47:32]));
            chk("wr_data0", wd0, e[31:0]);
         end
      end
      if (we1 === 1'b1) begin
         nw1++;
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_we1: got write @%h data %h want none", addr1, wd1);
         end else begin
            e = q1.pop_front();
            chk("wr_addr1", 32'(addr1), 32'(e[47:32]));
            chk("wr_data1", wd1, e[31:0]);
         end
      end
   end

   task automatic push_exp(input int off, input logic [31:0] w);
      q0.push_back({16'(off), w});
      q1.push_back({16'(off + B1), w});
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_crst0", crst0, 1);
      chk("rst_crst1", crst1, 1);
      chk("rst_ready0", rdy0, 0);
      chk("rst_we0", we0, 0);
      chk("rst_addr0", 32'(addr0), 0);
      chk("rst_addr1", 32'(addr1), B1);
      chk("rst_wdata0", wd0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_err0", err0, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("ready_low_after_rst", rdy0, 0);
      @(negedge clk);
      chk("ready_rise0", rdy0, 1);
      chk("ready_rise1", rdy1, 1);
      @(posedge clk); #1;
   endtask

   // Presents one byte and holds it until accepted; returns at posedge+1.
   task automatic send_byte(input logic [7:0] b, input bit gaps);
      bit ok;
      if (gaps) begin
         int g;
         g = $urandom_range(0, 5);
         repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk); #1;
         end
      end
      in_valid = 1'b1;
      in_data  = b;
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = rdy0;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      if (!ok) begin
         total++; bad++;
         $display("FAIL accept_timeout: byte %h not accepted, want accepted within 20 cycles", b);
      end
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int n;
      do_reset();
      nw0 = 0;
      nw1 = 0;
      for (int i = 0; i < 4; i++) send_byte(v.b[i], v.gaps);
      n = v.nb - 4;
      if (v.err) begin
         @(negedge clk);
         chk("err_flag0", err0, 1);
         chk("err_flag1", err1, 1);
         chk("err_ready0", rdy0, 0);
         chk("err_crst0", crst0, 1);
         chk("err_done0", done0, 0);
         repeat (4) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            @(negedge clk);
            chk("err_hold_ready", rdy0, 0);
            chk("err_hold_flag", err0, 1);
            chk("err_hold_crst", crst0, 1);
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
      end else if (n == 0) begin
         @(negedge clk);
         chk("zero_done0", done0, 1);
         chk("zero_crst0", crst0, 0);
         chk("zero_done1", done1, 1);
         chk("zero_ready0", rdy0, 0);
      end else begin
         for (int p = 0; p < n; p++) begin
            if ((p % 4 == 3) || (p == n - 1)) push_exp(4 * (p / 4), v.w[p / 4]);
            send_byte(v.b[4 + p], v.gaps);
         end
         @(negedge clk);
         chk("flush_we0", we0, 1);
         chk("flush_ready0", rdy0, 0);
         chk("flush_done0", done0, 0);
         chk("flush_crst0", crst0, 1);
         @(posedge clk); #1;
         @(negedge clk);
         chk("final_done0", done0, 1);
         chk("final_crst0", crst0, 0);
         chk("final_done1", done1, 1);
         chk("final_crst1", crst1, 0);
         chk("final_we0", we0, 0);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_hold_done", id), done0, (!v.err) ? 1 : 0);
      chk($sformatf("v%0d_hold_err", id), err0, v.err ? 1 : 0);
      chk($sformatf("v%0d_nwrites0", id), nw0, v.nw);
      chk($sformatf("v%0d_nwrites1", id), nw1, v.nw);
      chk($sformatf("v%0d_q0_left", id), q0.size(), 0);
      chk($sformatf("v%0d_q1_left", id), q1.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: N=8 full rate
      tv[0].nb = 12; tv[0].gaps = 0; tv[0].nw = 2; tv[0].err = 0;
      tv[0].b  = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00,
                   8'h93, 8'h05, 8'h10, 8'h00};
      tv[0].w  = '{32'h00000513, 32'h00100593};
      // 2: N=5, partial final word
      tv[1].nb = 9; tv[1].gaps = 0; tv[1].nw = 2; tv[1].err = 0;
      tv[1].b  = '{8'h05, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'hAB, 8'h00, 8'h00, 8'h00};
      tv[1].w  = '{32'h44332211, 32'h000000AB};
      // 3: N=0
      tv[2].nb = 4; tv[2].gaps = 0; tv[2].nw = 0; tv[2].err = 0;
      tv[2].b  = '{default: 8'h00};
      tv[2].w  = '{default: 32'h0};
      // 4: N=0x00010001 exceeds capacity
      tv[3].nb = 4; tv[3].gaps = 0; tv[3].nw = 0; tv[3].err = 1;
      tv[3].b  = '{8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h00, 8'h00};
      tv[3].w  = '{default: 32'h0};
      // 5: test 1 with random gaps
      tv[4] = tv[0];
      tv[4].gaps = 1;

      for (int t = 0; t < 5; t++) run_vec(tv[t], t + 1);

      // 6: reset after 6 payload bytes, then the full stream again.
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(tv[0].b[i], 0);
      for (int p = 0; p < 6; p++) begin
         if (p == 3) push_exp(0, tv[0].w[0]);
         send_byte(tv[0].b[4 + p], 0);
      end
      @(negedge clk);
      chk("mid_crst0", crst0, 1);
      chk("mid_done0", done0, 0);
      chk("mid_addr0", 32'(addr0), 4);
      chk("mid_q0_left", q0.size(), 0);
      @(posedge clk); #1;
      run_vec(tv[0], 6);

      // 7: reset coinciding with the final byte drops the pending write.
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(tv[0].b[i], 0);
      for (int p = 0; p < 7; p++) begin
         if (p == 3) push_exp(0, tv[0].w[0]);
         send_byte(tv[0].b[4 + p], 0);
      end
      in_valid = 1'b1;
      in_data  = tv[0].b[11];
      rst      = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("drop_we0", we0, 0);
      chk("drop_we1", we1, 0);
      chk("drop_ready0", rdy0, 0);
      chk("drop_crst0", crst0, 1);
      chk("drop_addr0", 32'(addr0), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("drop_q0_left", q0.size(), 0);
      chk("drop_q1_left", q1.size(), 0);
      chk("drop_done0", done0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
